// File: rtl/serial_frame_rx.sv
// Start-bit framed serial receiver: LSB-first deserialiser with optional even
// parity, single-cycle result strobes and a wrapping good-frame counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a 0 start bit
// ST_DATA   | shifting in DATA_BITS data bits, LSB first
// ST_PARITY | sampling the even-parity bit (PARITY_EN=1 only)
// ST_STOP   | sampling the stop bit, issuing Valid / ParErr / FrameErr
// ST_BRK    | line held low after a framing error, waiting for a 1
module serial_frame_rx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Din,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 Valid,
    output logic                 FrameErr,
    output logic                 ParErr,
    output logic                 Busy,
    output logic [7:0]           FrameCnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            Dout     <= '0;
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            ParErr   <= 1'b0;
            Busy     <= 1'b0;
            FrameCnt <= '0;
        end else begin
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            ParErr   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!Din) begin
                        state   <= ST_DATA;
                        bit_cnt <= LAST_BIT;
                        par_bad <= 1'b0;
                        Busy    <= 1'b1;
                    end
                end
                ST_DATA: begin
                    // Right shift: the first bit received ends up in bit 0.
                    shreg <= {Din, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == 3'd0) begin
                        state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_bad <= (^shreg) ^ Din;
                    state   <= ST_STOP;
                end
                ST_STOP: begin
                    if (Din) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                        if ((PARITY_EN != 0) && par_bad) begin
                            ParErr <= 1'b1;
                        end else begin
                            Dout     <= shreg;
                            Valid    <= 1'b1;
                            FrameCnt <= FrameCnt + 8'd1;
                        end
                    end else begin
                        // A framing error overrides any parity result.
                        FrameErr <= 1'b1;
                        state    <= ST_BRK;
                    end
                end
                ST_BRK: begin
                    if (Din) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
